dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbiter sharing a single-port data memory between the cpu MEM stage and a debug/loader port.
// Build option DMEM_ARB_RR_EN selects round-robin arbitration instead of cpu priority with a starvation guard.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_dwe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_DBG  = 2'd2;

  logic       cpu_win;
  logic       dbg_win;
  logic [1:0] rd_owner_q;
  logic [1:0] rd_owner_d;

`ifdef DMEM_ARB_RR_EN
  // last_win_q: 1 = dbg won the most recent grant, 0 = cpu.
  logic last_win_q;
  logic last_win_d;

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      if (cpu_req && dbg_req) begin
        cpu_win = last_win_q;
        dbg_win = !last_win_q;
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req;
      end
    end
  end

  always_comb begin
    last_win_d = last_win_q;
    if (cpu_win)      last_win_d = 1'b0;
    else if (dbg_win) last_win_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) last_win_q <= 1'b1;
    else     last_win_q <= last_win_d;
  end
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (!rst) begin
      if (cpu_req && dbg_req) begin
        dbg_win = (wait_cnt_q == MAX_WAIT_C);
        cpu_win = !dbg_win;
      end else begin
        cpu_win = cpu_req;
        dbg_win = dbg_req;
      end
    end
  end

  always_comb begin
    wait_cnt_d = 4'd0;
    if (dbg_req && !dbg_win)
      wait_cnt_d = (wait_cnt_q == MAX_WAIT_C) ? wait_cnt_q : wait_cnt_q + 4'd1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= 4'd0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`endif

  assign cpu_gnt = cpu_win;
  assign dbg_gnt = dbg_win;

  always_comb begin
    mem_dwe   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_dwe   = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_win) begin
      mem_dwe   = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_win && !cpu_we)      rd_owner_d = OWN_CPU;
    else if (dbg_win && !dbg_we) rd_owner_d = OWN_DBG;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_owner_q <= OWN_NONE;
    else     rd_owner_q <= rd_owner_d;
  end

  // A read whose data cycle coincides with rst is dropped, so rst masks rvalid directly.
  assign cpu_rvalid = (rd_owner_q == OWN_CPU) && !rst;
  assign dbg_rvalid = (rd_owner_q == OWN_DBG) && !rst;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: behavioural 256x16 memory, read-return scoreboard queue.
// Expectations follow the DMEM_ARB_RR_EN build option when it is defined.
module tb_dmem_arbiter;

  typedef enum logic [1:0] {S_NONE, S_CPU, S_DBG} side_e;
  typedef struct {
    side_e       side;
    logic [15:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr;
  logic [15:0] cpu_wdata, dbg_wdata;
  logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        mem_dwe;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  rd_exp_t     sb[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_dwe(mem_dwe), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory with registered read data (read-before-write on the same edge).
  always @(posedge clk) begin
    if (mem_dwe) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [7:0] a, input logic [15:0] wd);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  task automatic set_dbg(input logic req, input logic we, input logic [7:0] a, input logic [15:0] wd);
    dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
  endtask

  // Inputs are already driven (just after a posedge). Check mid-cycle, then advance one cycle.
  task automatic step(input string tag, input logic ecg, input logic edg);
    rd_exp_t     e;
    rd_exp_t     nxt;
    logic        e_we;
    logic [7:0]  e_addr;
    logic [15:0] e_wd;
    @(negedge clk);
    e = sb.pop_front();
    if (rst) e = '{side: S_NONE, data: 16'h0};
    check({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'(e.side == S_CPU));
    check({tag, ".cpu_rdata"},  32'(cpu_rdata),  (e.side == S_CPU) ? 32'(e.data) : 32'h0);
    check({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'(e.side == S_DBG));
    check({tag, ".dbg_rdata"},  32'(dbg_rdata),  (e.side == S_DBG) ? 32'(e.data) : 32'h0);
    check({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(ecg));
    check({tag, ".dbg_gnt"}, 32'(dbg_gnt), 32'(edg));
    e_we = 1'b0; e_addr = 8'h0; e_wd = 16'h0;
    if (ecg)      begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
    else if (edg) begin e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; end
    check({tag, ".mem_dwe"},   32'(mem_dwe),   32'(e_we));
    check({tag, ".mem_addr"},  32'(mem_addr),  32'(e_addr));
    check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(e_wd));
    nxt = '{side: S_NONE, data: 16'h0};
    if ((ecg || edg) && !rst) begin
      if (e_we) ref_mem[e_addr] = e_wd;
      else      nxt = '{side: ecg ? S_CPU : S_DBG, data: ref_mem[e_addr]};
    end
    sb.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i + 9);
      ref_mem[i] = 16'(i + 9);
    end
    sb.push_back('{side: S_NONE, data: 16'h0});

    // Reset with a cpu write pending: nothing may be granted or written.
    rst = 1'b1;
    set_cpu(1'b1, 1'b1, 8'h01, 16'hffff);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000);
    step("rst0", 1'b0, 1'b0);
    step("rst1", 1'b0, 1'b0);
    rst = 1'b0;
`ifndef DMEM_ARB_RR_EN
    check("wait_cnt_after_rst", 32'(dut.wait_cnt_q), 32'h0);
`endif

    // Uncontested cpu read of addr 1, then idle while the data returns.
    set_cpu(1'b1, 1'b0, 8'h01, 16'h0000);
    step("cpu_rd1", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    step("cpu_rd1_ret", 1'b0, 1'b0);

    // dbg write 0x10 then read it back.
    set_dbg(1'b1, 1'b1, 8'h10, 16'h1234);
    step("dbg_wr10", 1'b0, 1'b1);
    set_dbg(1'b1, 1'b0, 8'h10, 16'h0000);
    step("dbg_rd10", 1'b0, 1'b1);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000);
    step("dbg_rd10_ret", 1'b0, 1'b0);

    // dbg write loses to cpu, then dbg drops its request: 0x20 must stay untouched.
    set_cpu(1'b1, 1'b0, 8'h01, 16'h0000);
    set_dbg(1'b1, 1'b1, 8'h20, 16'hdead);
    step("abandon_lose", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000);
    step("abandon_drop", 1'b0, 1'b0);
    set_cpu(1'b1, 1'b0, 8'h20, 16'h0000);
    step("cpu_rd20", 1'b1, 1'b0);

    // Alternate cpu read 2 / dbg read 3 back-to-back (first cpu step overlaps the 0x20 return).
    for (int k = 0; k < 6; k++) begin
      set_cpu(!k[0], 1'b0, 8'h02, 16'h0000);
      set_dbg(k[0],  1'b0, 8'h03, 16'h0000);
      step("alt", !k[0], k[0]);
    end
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000);
    step("alt_ret", 1'b0, 1'b0);

    // cpu write then read of the same address in consecutive cycles.
    set_cpu(1'b1, 1'b1, 8'h05, 16'hbeef);
    step("cpu_wr5", 1'b1, 1'b0);
    set_cpu(1'b1, 1'b0, 8'h05, 16'h0000);
    step("cpu_rd5", 1'b1, 1'b0);
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    step("cpu_rd5_ret", 1'b0, 1'b0);

    // Both sides requesting for 10 cycles from a fresh reset.
    rst = 1'b1;
    step("rst_contend", 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic edg;
`ifdef DMEM_ARB_RR_EN
      edg = k[0];
`else
      edg = (k == 4) || (k == 9);
`endif
      set_cpu(1'b1, 1'b0, 8'(k), 16'h0000);
      set_dbg(1'b1, 1'b0, 8'(8'h40 + k), 16'h0000);
      step("contend", !edg, edg);
`ifndef DMEM_ARB_RR_EN
      if (k == 3) check("wait_cnt_sat", 32'(dut.wait_cnt_q), 32'h4);
      if (k == 4) check("wait_cnt_clr", 32'(dut.wait_cnt_q), 32'h0);
`endif
    end

    // cpu read granted, then rst: the in-flight read must never raise rvalid.
    set_cpu(1'b1, 1'b0, 8'h07, 16'h0000);
    set_dbg(1'b1, 1'b0, 8'h08, 16'h0000);
    step("rd_before_rst", 1'b1, 1'b0);
    rst = 1'b1;
    set_cpu(1'b0, 1'b0, 8'h00, 16'h0000);
    set_dbg(1'b0, 1'b0, 8'h00, 16'h0000);
    step("rst_drop", 1'b0, 1'b0);
    rst = 1'b0;
    step("after_rst_drop", 1'b0, 1'b0);
`ifndef DMEM_ARB_RR_EN
    check("wait_cnt_rst_drop", 32'(dut.wait_cnt_q), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
